// File: rtl/inv_pkg.sv
// Shared types and constants for the sequential modular-inverse engine.
package inv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } inv_state_e;

  // Library default operand width; instances may override IP_WIDTH.
  localparam int INV_DEF_WIDTH = 7;

  // Signed Bezout-coefficient width and worst-case Euclid step count at the default width.
  localparam int T_WIDTH       = INV_DEF_WIDTH + 1;
  localparam int INV_MAX_STEPS = 2 * INV_DEF_WIDTH;

  // Width-generic forms of the constants above, for parametrised instances.
  function automatic int calc_t_width(input int w);
    return w + 1;
  endfunction

  function automatic int calc_max_steps(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/inv_euclid_step.sv
// One combinational extended-Euclid quotient step: (r0,r1,t0,t1) -> next tuple.
module inv_euclid_step
  import inv_pkg::*;
#(
  parameter int IP_WIDTH = 7
) (
  input  logic        [IP_WIDTH-1:0] r0,
  input  logic        [IP_WIDTH-1:0] r1,
  input  logic signed [IP_WIDTH:0]   t0,
  input  logic signed [IP_WIDTH:0]   t1,
  output logic        [IP_WIDTH-1:0] r0_next,
  output logic        [IP_WIDTH-1:0] r1_next,
  output logic signed [IP_WIDTH:0]   t0_next,
  output logic signed [IP_WIDTH:0]   t1_next
);

  localparam int TW = calc_t_width(IP_WIDTH);

  logic        [IP_WIDTH-1:0] q;
  logic signed [TW-1:0]       q_s;
  logic signed [TW-1:0]       prod;

  // Quotient and remainder/coefficient update; q*t1 truncated to TW bits is exact since |t| <= m.
  always_comb begin
    q       = (r1 != '0) ? (r0 / r1) : '0;
    q_s     = signed'({1'b0, q});
    prod    = q_s * t1;
    r0_next = r1;
    r1_next = r0 - (q * r1);
    t0_next = t1;
    t1_next = t0 - prod;
  end

endmodule

// File: rtl/inv_seq_ip.sv
// Multi-cycle modular-inverse engine: inverts min(A,B) modulo max(A,B),
// one Euclid quotient step per cycle, result presented as a one-cycle strobe.
module inv_seq_ip
  import inv_pkg::*;
#(
  parameter int IP_WIDTH = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IP_WIDTH-1:0] in_1,
  input  logic [IP_WIDTH-1:0] in_2,
  output logic                out_valid,
  output logic [IP_WIDTH-1:0] out_inv,
  output logic                out_err
);

  localparam int TW = calc_t_width(IP_WIDTH);

  inv_state_e state;

  logic        [IP_WIDTH-1:0] m_q, a_q, r0_q, r1_q;
  logic signed [TW-1:0]       t0_q, t1_q;

  logic        [IP_WIDTH-1:0] r0_n, r1_n;
  logic signed [TW-1:0]       t0_n, t1_n;

  logic        [IP_WIDTH-1:0] in_max, in_min;
  logic signed [TW-1:0]       t0_norm;
  logic                       inv_ok;

  inv_euclid_step #(
    .IP_WIDTH(IP_WIDTH)
  ) u_step (
    .r0      (r0_q),
    .r1      (r1_q),
    .t0      (t0_q),
    .t1      (t1_q),
    .r0_next (r0_n),
    .r1_next (r1_n),
    .t0_next (t0_n),
    .t1_next (t1_n)
  );

  // Operand ordering: larger operand is the modulus.
  always_comb begin
    if (in_1 >= in_2) begin
      in_max = in_1;
      in_min = in_2;
    end else begin
      in_max = in_2;
      in_min = in_1;
    end
  end

  // Result normalisation: gcd must be 1 with a nonzero value distinct from the modulus.
  always_comb begin
    t0_norm = t0_q[TW-1] ? (t0_q + signed'({1'b0, m_q})) : t0_q;
    inv_ok  = (r0_q == {{(IP_WIDTH-1){1'b0}}, 1'b1}) && (a_q != '0) && (a_q != m_q);
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_inv   <= '0;
      out_err   <= 1'b0;
      m_q       <= '0;
      a_q       <= '0;
      r0_q      <= '0;
      r1_q      <= '0;
      t0_q      <= '0;
      t1_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            m_q      <= in_max;
            a_q      <= in_min;
            r0_q     <= in_max;
            r1_q     <= in_min;
            t0_q     <= '0;
            t1_q     <= TW'(1);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (r1_q != '0) begin
            r0_q <= r0_n;
            r1_q <= r1_n;
            t0_q <= t0_n;
            t1_q <= t1_n;
          end else begin
            out_valid <= 1'b1;
            out_inv   <= inv_ok ? IP_WIDTH'(t0_norm) : '0;
            out_err   <= ~inv_ok;
            state     <= DONE;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          out_inv   <= '0;
          out_err   <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_seq_ip.sv
// Scoreboard bench for inv_seq_ip: directed cases, busy/reset scenarios,
// and a randomly-ordered sweep of every operand pair at width 7.
module tb_inv_seq_ip;

  localparam int W       = 7;
  localparam int MAX_LAT = 2 * W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_1 = '0;
  logic [W-1:0] in_2 = '0;
  logic         out_valid;
  logic [W-1:0] out_inv;
  logic         out_err;

  inv_seq_ip #(
    .IP_WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_1      (in_1),
    .in_2      (in_2),
    .out_valid (out_valid),
    .out_inv   (out_inv),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] inv;
    logic         err;
    int unsigned  acc;
    int unsigned  lat;
    int unsigned  a;
    int unsigned  b;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: brute-force inverse search plus a plain remainder-sequence step count.
  task automatic model(input int unsigned x, input int unsigned y,
                       output logic [W-1:0] inv, output logic err, output int unsigned lat);
    int unsigned m, a, r0, r1, tmp, steps;
    m = (x > y) ? x : y;
    a = (x > y) ? y : x;
    r0 = m; r1 = a; steps = 0;
    while (r1 != 0) begin
      tmp = r0 % r1; r0 = r1; r1 = tmp; steps++;
    end
    lat = steps + 1;
    inv = '0;
    err = 1'b1;
    if (a != 0 && a != m && r0 == 1) begin
      for (int unsigned k = 1; k < m; k++) begin
        if ((a * k) % m == 1) begin
          inv = W'(k);
          err = 1'b0;
          break;
        end
      end
    end
  endtask

  // Present operands from a negedge, wait for acceptance, then log the expectation.
  task automatic send(input int unsigned x, input int unsigned y,
                      input logic [W-1:0] inv, input logic err, input int unsigned lat);
    exp_t e;
    int   guard;
    in_1 = W'(x);
    in_2 = W'(y);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 4 * MAX_LAT) begin
        tests++; fails++;
        $display("FAIL accept_timeout (%0d,%0d): in_ready=%0b, required 1", x, y, in_ready);
        return;
      end
    end
    @(posedge clk);
    @(negedge clk);
    e.inv = inv; e.err = err; e.acc = cyc; e.lat = lat; e.a = x; e.b = y;
    sb.push_back(e);
  endtask

  task automatic send_model(input int unsigned x, input int unsigned y);
    logic [W-1:0] inv;
    logic         err;
    int unsigned  lat;
    model(x, y, inv, err, lat);
    send(x, y, inv, err, lat);
  endtask

  task automatic drain();
    int guard = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && guard < 8 * MAX_LAT) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor: pop and compare on every strobe; outputs must be zero otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_strobe: out_valid=1 inv=%0d err=%0b, required no strobe", out_inv, out_err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          tests++;
          if (out_inv !== e.inv || out_err !== e.err || (cyc - e.acc) != e.lat) begin
            fails++;
            $display("FAIL result (%0d,%0d): inv=%0d err=%0b lat=%0d, required inv=%0d err=%0b lat=%0d",
                     e.a, e.b, out_inv, out_err, cyc - e.acc, e.inv, e.err, e.lat);
          end
        end
      end else begin
        tests++;
        if (out_inv !== '0 || out_err !== 1'b0) begin
          fails++;
          $display("FAIL idle_outputs: inv=%0d err=%0b, required 0 0", out_inv, out_err);
        end
        if (sb.size() != 0 && (cyc - sb[0].acc) > MAX_LAT) begin
          tests++; fails++;
          $display("FAIL strobe_timeout (%0d,%0d): waited %0d cycles, required <= %0d",
                   sb[0].a, sb[0].b, cyc - sb[0].acc, MAX_LAT);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_inv !== '0 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: rdy=%0b vld=%0b inv=%0d err=%0b, required 1 0 0 0",
               in_ready, out_valid, out_inv, out_err);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived expectations.
    send(3, 7, 7'd5, 1'b0, 3);
    drain();
    send(7, 3, 7'd5, 1'b0, 3);
    drain();
    send(126, 127, 7'd126, 1'b0, 3);
    drain();
    send(1, 127, 7'd1, 1'b0, 2);
    drain();
    send(6, 4, 7'd0, 1'b1, 3);
    drain();
    send(5, 5, 7'd0, 1'b1, 2);
    drain();
    send(0, 5, 7'd0, 1'b1, 1);
    drain();
    send(0, 0, 7'd0, 1'b1, 1);
    drain();

    // Busy input: (10,3) held valid during the (3,7) run, taken only when ready returns.
    send(3, 7, 7'd5, 1'b0, 3);
    send(10, 3, 7'd7, 1'b0, 3);
    drain();

    // Reset mid-calculation discards the operation without a strobe.
    send(126, 127, 7'd0, 1'b0, 3);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_inv !== '0 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL midcalc_reset: rdy=%0b vld=%0b inv=%0d err=%0b, required 1 0 0 0",
               in_ready, out_valid, out_inv, out_err);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send(3, 7, 7'd5, 1'b0, 3);
    drain();

    // Every unordered pair, randomly oriented, back-to-back.
    for (int unsigned i = 0; i < (1 << W); i++) begin
      for (int unsigned j = i; j < (1 << W); j++) begin
        if ($urandom_range(1, 0) == 1) send_model(i, j);
        else                           send_model(j, i);
      end
    end
    drain();

    // Random pairs with random idle gaps.
    for (int k = 0; k < 300; k++) begin
      send_model($urandom_range((1 << W) - 1, 0), $urandom_range((1 << W) - 1, 0));
      if ($urandom_range(3, 0) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
    end
    drain();

    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_residue: %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
